// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
//   Holds one operation at a time. Single-cycle ops cover add, sub, logic and
//   shifts. Unsigned multiply is iterative, using shift-add over a 2*WIDTH
//   accumulator. Illegal selects complete as single-cycle ops with err set.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready is combinational)
//   a, b, sel            operands and operation select, latched at accept
//   out_valid/out_ready  result handshake
//   result, flag_z, flag_n, flag_c, flag_v, err   registered result and status
//
// state | meaning
// IDLE  | ready to accept an operation
// MUL   | iterating shift-add, one multiplier bit per cycle
// DONE  | result captured, then held until the consumer takes it
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [3:0]         sel_q;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic               accept;

    logic [WIDTH:0]     sum, diff;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_err;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (sel == 4'b1000) ? MUL : DONE;
            MUL:  if (cnt == '0) state_nxt = DONE;
            DONE: if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sum   = {1'b0, a_q} + {1'b0, b_q};
    assign diff  = {1'b0, a_q} - {1'b0, b_q};
    assign shamt = b_q[SHW-1:0];

    // Evaluated from the latched operands; sampled in the first DONE cycle.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (sel_q)
            4'b0000: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            4'b0001: begin
                alu_res = diff[MSB:0];
                alu_c   = diff[WIDTH];  // borrow out equals a < b unsigned
                alu_v   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            4'b0010: alu_res = a_q & b_q;
            4'b0011: alu_res = a_q | b_q;
            4'b0100: alu_res = a_q ^ b_q;
            4'b0101: alu_res = a_q << shamt;
            4'b0110: alu_res = a_q >> shamt;
            4'b0111: alu_res = $signed(a_q) >>> shamt;
            4'b1000: begin
                alu_res = acc[MSB:0];
                alu_v   = |acc[2*WIDTH-1:WIDTH];
            end
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q    <= a;
                        b_q    <= b;
                        sel_q  <= sel;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        cnt    <= SHW'(WIDTH - 1);
                    end
                end
                MUL: begin
                    // Last step happens on the same edge that leaves MUL.
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                DONE: begin
                    if (!out_valid) begin
                        result    <= alu_res;
                        flag_z    <= (alu_res == '0);
                        flag_n    <= alu_res[MSB];
                        flag_c    <= alu_c;
                        flag_v    <= alu_v;
                        err       <= alu_err;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=16).
//   Flag vectors compared as {flag_z, flag_n, flag_c, flag_v, err}.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [3:0]  sel = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        flag_z, flag_n, flag_c, flag_v, err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .flag_v(flag_v), .err(err)
    );

    task automatic issue(input logic [15:0] ta, input logic [15:0] tbv, input logic [3:0] ts);
        @(negedge clk);
        a = ta; b = tbv; sel = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output logic saw_ready);
        lat = 0;
        saw_ready = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (in_ready) saw_ready = 1'b1;
        end while (!out_valid && lat < 40);
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%0b exp=0", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if ({result, flag_z, flag_n, flag_c, flag_v, err} !== 21'h0)
            $display("FAIL rst_outputs got=%h/%b exp=0000/00000", result, {flag_z, flag_n, flag_c, flag_v, err}); else pass_cnt++;
        rst = 1'b0; #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got=%0b exp=1", in_ready); else pass_cnt++;
        issue(16'h0100, 16'h0100, 4'b1000);
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL midmul_rst_ready got=%0b exp=0", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0 || result !== 16'h0000)
            $display("FAIL midmul_rst_out got=%0b/%h exp=0/0000", out_valid, result); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        repeat (25) @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL abort_no_result got=%0b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL abort_ready got=%0b exp=1", in_ready); else pass_cnt++;
    endtask

    task automatic test_add();
        int lat; logic sr;
        issue(16'h7FFF, 16'h0001, 4'b0000);
        wait_valid(lat, sr);
        total_cnt++; if (lat !== 1) $display("FAIL add_latency got=%0d exp=1", lat); else pass_cnt++;
        total_cnt++; if (result !== 16'h8000) $display("FAIL add_ovf_result got=%h exp=8000", result); else pass_cnt++;
        total_cnt++; if ({flag_z, flag_n, flag_c, flag_v, err} !== 5'b01010)
            $display("FAIL add_ovf_flags got=%b exp=01010", {flag_z, flag_n, flag_c, flag_v, err}); else pass_cnt++;
        take();
        issue(16'hFFFF, 16'h0001, 4'b0000);
        wait_valid(lat, sr);
        total_cnt++; if (result !== 16'h0000) $display("FAIL add_carry_result got=%h exp=0000", result); else pass_cnt++;
        total_cnt++; if ({flag_z, flag_n, flag_c, flag_v, err} !== 5'b10100)
            $display("FAIL add_carry_flags got=%b exp=10100", {flag_z, flag_n, flag_c, flag_v, err}); else pass_cnt++;
        take();
    endtask

    task automatic test_sub();
        int lat; logic sr;
        issue(16'h0003, 16'h0005, 4'b0001);
        wait_valid(lat, sr);
        total_cnt++; if (lat !== 1) $display("FAIL sub_latency got=%0d exp=1", lat); else pass_cnt++;
        total_cnt++; if (result !== 16'hFFFE) $display("FAIL sub_result got=%h exp=fffe", result); else pass_cnt++;
        total_cnt++; if ({flag_z, flag_n, flag_c, flag_v, err} !== 5'b01100)
            $display("FAIL sub_flags got=%b exp=01100", {flag_z, flag_n, flag_c, flag_v, err}); else pass_cnt++;
        take();
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL sub_handshake got=%0b/%0b exp=0/1", out_valid, in_ready); else pass_cnt++;
    endtask

    task automatic test_mul();
        int lat; logic sr;
        issue(16'h0100, 16'h0100, 4'b1000);
        wait_valid(lat, sr);
        total_cnt++; if (lat !== 17) $display("FAIL mul_latency got=%0d exp=17", lat); else pass_cnt++;
        total_cnt++; if (sr !== 1'b0) $display("FAIL mul_in_ready got=%0b exp=0", sr); else pass_cnt++;
        total_cnt++; if (result !== 16'h0000) $display("FAIL mul_ovf_result got=%h exp=0000", result); else pass_cnt++;
        total_cnt++; if ({flag_z, flag_n, flag_c, flag_v, err} !== 5'b10010)
            $display("FAIL mul_ovf_flags got=%b exp=10010", {flag_z, flag_n, flag_c, flag_v, err}); else pass_cnt++;
        take();
        issue(16'h00FF, 16'h0003, 4'b1000);
        wait_valid(lat, sr);
        total_cnt++; if (result !== 16'h02FD) $display("FAIL mul_result got=%h exp=02fd", result); else pass_cnt++;
        total_cnt++; if ({flag_z, flag_n, flag_c, flag_v, err} !== 5'b00000)
            $display("FAIL mul_flags got=%b exp=00000", {flag_z, flag_n, flag_c, flag_v, err}); else pass_cnt++;
        take();
    endtask

    task automatic test_shift();
        int lat; logic sr;
        issue(16'h8000, 16'h0013, 4'b0111);
        wait_valid(lat, sr);
        total_cnt++; if (result !== 16'hF000) $display("FAIL sra_result got=%h exp=f000", result); else pass_cnt++;
        take();
        issue(16'h0001, 16'h000F, 4'b0101);
        wait_valid(lat, sr);
        total_cnt++; if (result !== 16'h8000) $display("FAIL sll_result got=%h exp=8000", result); else pass_cnt++;
        total_cnt++; if ({flag_z, flag_n, flag_c, flag_v, err} !== 5'b01000)
            $display("FAIL sll_flags got=%b exp=01000", {flag_z, flag_n, flag_c, flag_v, err}); else pass_cnt++;
        take();
        issue(16'h8000, 16'h000F, 4'b0110);
        wait_valid(lat, sr);
        total_cnt++; if (result !== 16'h0001) $display("FAIL srl_result got=%h exp=0001", result); else pass_cnt++;
        take();
    endtask

    task automatic test_backpressure();
        int lat; logic sr;
        int bad;
        issue(16'hA5A5, 16'h5A5A, 4'b0100);
        wait_valid(lat, sr);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (result !== 16'hFFFF || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL bp_hold got=%0d_bad_cycles exp=0 (result=%h)", bad, result); else pass_cnt++;
        total_cnt++; if ({flag_z, flag_n, flag_c, flag_v, err} !== 5'b01000)
            $display("FAIL xor_flags got=%b exp=01000", {flag_z, flag_n, flag_c, flag_v, err}); else pass_cnt++;
        take();
        issue(16'h1234, 16'h5678, 4'b1111);
        wait_valid(lat, sr);
        total_cnt++; if (lat !== 1) $display("FAIL illegal_latency got=%0d exp=1", lat); else pass_cnt++;
        total_cnt++; if (result !== 16'h0000) $display("FAIL illegal_result got=%h exp=0000", result); else pass_cnt++;
        total_cnt++; if ({flag_z, flag_n, flag_c, flag_v, err} !== 5'b10001)
            $display("FAIL illegal_flags got=%b exp=10001", {flag_z, flag_n, flag_c, flag_v, err}); else pass_cnt++;
        take();
    endtask

    task automatic test_back_to_back();
        int lat; logic sr;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready got=%0b exp=1", in_ready); else pass_cnt++;
        issue(16'h0F0F, 16'h00FF, 4'b0011);
        wait_valid(lat, sr);
        total_cnt++; if (result !== 16'h0FFF || err !== 1'b0)
            $display("FAIL b2b_or got=%h/%0b exp=0fff/0", result, err); else pass_cnt++;
        take();
        issue(16'h0F0F, 16'h00FF, 4'b0010);
        wait_valid(lat, sr);
        total_cnt++; if (result !== 16'h000F) $display("FAIL b2b_and got=%h exp=000f", result); else pass_cnt++;
        take();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_shift();
        test_backpressure();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
